// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined eight-op bitwise logic unit with result flags and valid/ready backpressure
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_par
);
  localparam int PW = WIDTH + 3;
  logic [STAGES-1:0] valid_q, valid_d, src_v;
  logic [PW-1:0]     data_q [STAGES];
  logic [PW-1:0]     data_d [STAGES];
  logic [PW-1:0]     src_p  [STAGES];
  logic [STAGES:0]   rdy;
  logic [WIDTH-1:0]  res;
  always_comb begin
    res = in_op == 3'd0 ? ~in_a :
          in_op == 3'd1 ? in_a & in_b :
          in_op == 3'd2 ? in_a | in_b :
          in_op == 3'd3 ? in_a ^ in_b :
          in_op == 3'd4 ? ~(in_a & in_b) :
          in_op == 3'd5 ? ~(in_a | in_b) :
          in_op == 3'd6 ? ~(in_a ^ in_b) : in_a;
    // a stage can take new data when empty or when its successor is taking its contents
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) rdy[k] = !valid_q[k] || rdy[k+1];
    src_v[0] = in_valid;
    src_p[0] = {res, res == '0, &res, ^res};
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = valid_q[k-1];
      src_p[k] = data_q[k-1];
    end
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = rdy[k] ? src_v[k] : valid_q[k];
      data_d[k]  = rdy[k] && src_v[k] ? src_p[k] : data_q[k];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign in_ready  = rdy[0];
  assign out_valid = valid_q[STAGES-1];
  assign {out_s, out_zero, out_ones, out_par} = data_q[STAGES-1];
endmodule
